uart_byte_link: RTL and testbench

//  Serial front end for the ioports command engine: 8N1 UART RX turns host bytes into one-cycle

---
 rtl/uart_byte_link_pkg.sv | 33 +++
 rtl/uart_byte_link_rx_core.sv | 132 +++++++++++++
 rtl/uart_byte_link.sv | 131 +++++++++++++
 tb/tb_uart_byte_link.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_byte_link_pkg.sv
// -----------------------------------------------------------------------------
// uart_byte_link_pkg
// Shared definitions for the UART byte link. It holds the default bit divisor,
// the default depth of the rxd synchronizer, the RX and TX state encodings, and
// a helper that sizes the bit-period counters.
// -----------------------------------------------------------------------------
package uart_byte_link_pkg;

    localparam int DIVISOR_DEF    = 868;  // 100 MHz / 115200 baud
    localparam int SYNC_DEPTH_DEF = 2;

    typedef enum logic [2:0] {
        R_IDLE   = 3'd0,
        R_START  = 3'd1,
        R_DATA   = 3'd2,
        R_STOP   = 3'd3,
        R_WAITHI = 3'd4
    } rx_state_t;

    typedef enum logic [2:0] {
        T_IDLE    = 3'd0,
        T_START   = 3'd1,
        T_DATA    = 3'd2,
        T_STOP    = 3'd3,
        T_RELEASE = 3'd4
    } tx_state_t;

    // Width of a down-counter that must hold values up to div-1.
    function automatic int cnt_width(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/uart_byte_link_rx_core.sv
// -----------------------------------------------------------------------------
// uart_byte_link_rx_core
// 8N1 UART receiver. The block synchronizes rxd, then finds the middle of the
// start bit and samples every following bit at its centre. When the stop bit is
// high, it presents the byte with a one-cycle load strobe. When the stop bit is
// low, it raises a one-cycle frame-error strobe and drops the byte.
// Ports:
//   clk, reset   master clock, synchronous active-high reset
//   rxd_i        asynchronous serial input, idle high
//   load_o       one-cycle strobe, data_o holds a new byte
//   data_o       last good byte, stable until the next load_o
//   frame_err_o  one-cycle strobe, stop bit sampled low
// -----------------------------------------------------------------------------
module uart_byte_link_rx_core
    import uart_byte_link_pkg::*;
#(
    parameter int DIVISOR    = DIVISOR_DEF,
    parameter int SYNC_DEPTH = SYNC_DEPTH_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd_i,
    output logic       load_o,
    output logic [7:0] data_o,
    output logic       frame_err_o
);

    localparam int            CW      = cnt_width(DIVISOR);
    localparam logic [CW-1:0] HALF_M1 = CW'(DIVISOR / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(DIVISOR - 1);
    localparam logic [CW-1:0] CNT_0   = CW'(0);

    logic [SYNC_DEPTH-1:0] sync_q;
    logic                  rxd_s;
    rx_state_t             state_q;
    logic [CW-1:0]         cnt_q;
    logic [2:0]            bit_q;
    logic [7:0]            shift_q;
    logic [7:0]            data_q;
    logic                  load_q;
    logic                  err_q;

    // rxd synchronizer; it resets to idle-high so that reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {SYNC_DEPTH{1'b1}};
        end else begin
            sync_q <= {sync_q[SYNC_DEPTH-2:0], rxd_i};
        end
    end

    assign rxd_s = sync_q[SYNC_DEPTH-1];

    // RX framing FSM. A down-counter that ends at zero spaces the samples.
    // Sampling starts half a bit in, so every bit is sampled at its centre.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= R_IDLE;
            cnt_q   <= CNT_0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            data_q  <= 8'h00;
            load_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            load_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                R_IDLE: begin
                    if (!rxd_s) begin
                        state_q <= R_START;
                        cnt_q   <= HALF_M1;
                    end
                end
                R_START: begin
                    if (cnt_q == CNT_0) begin
                        if (rxd_s) begin
                            state_q <= R_IDLE;   // too short to be a start bit
                        end else begin
                            state_q <= R_DATA;
                            cnt_q   <= FULL_M1;
                            bit_q   <= 3'd0;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                R_DATA: begin
                    if (cnt_q == CNT_0) begin
                        shift_q <= {rxd_s, shift_q[7:1]};   // LSB arrives first
                        cnt_q   <= FULL_M1;
                        if (bit_q == 3'd7) begin
                            state_q <= R_STOP;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                R_STOP: begin
                    if (cnt_q == CNT_0) begin
                        if (rxd_s) begin
                            data_q  <= shift_q;
                            load_q  <= 1'b1;
                            state_q <= R_IDLE;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= R_WAITHI;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                R_WAITHI: begin
                    // A held-low line (break) must not count as a new start bit.
                    if (rxd_s) begin
                        state_q <= R_IDLE;
                    end
                end
                default: begin
                    state_q <= R_IDLE;
                end
            endcase
        end
    end

    assign load_o      = load_q;
    assign data_o      = data_q;
    assign frame_err_o = err_q;

endmodule

// File: rtl/uart_byte_link.sv
// -----------------------------------------------------------------------------
// uart_byte_link
// Byte transport between the USB-UART pins and the ioports command engine.
// Bytes received on rxd appear on datain with a one-cycle load strobe. Bytes
// offered on dataout/enout are sent on txd as 8N1 frames under a ready
// handshake. The RX path and the TX path are independent of each other.
// Ports:
//   clk, reset    master clock, synchronous active-high reset
//   rxd / txd     UART pins, both idle high
//   load, datain  received byte strobe and value
//   rx_frame_err  one-cycle strobe, received stop bit was low
//   ready         TX can take a byte
//   enout         ioports offers dataout; held until ready falls
//   dataout       byte to transmit, captured once per frame
// -----------------------------------------------------------------------------
module uart_byte_link
    import uart_byte_link_pkg::*;
#(
    parameter int DIVISOR    = DIVISOR_DEF,
    parameter int SYNC_DEPTH = SYNC_DEPTH_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic       txd,
    output logic       load,
    output logic [7:0] datain,
    output logic       ready,
    input  logic       enout,
    input  logic [7:0] dataout,
    output logic       rx_frame_err
);

    localparam int            CW      = cnt_width(DIVISOR);
    localparam logic [CW-1:0] FULL_M1 = CW'(DIVISOR - 1);
    localparam logic [CW-1:0] CNT_0   = CW'(0);

    tx_state_t     tx_state_q;
    logic [CW-1:0] tx_cnt_q;
    logic [2:0]    tx_bit_q;
    logic [7:0]    tx_shift_q;
    logic          txd_q;
    logic          ready_q;

    uart_byte_link_rx_core #(
        .DIVISOR    (DIVISOR),
        .SYNC_DEPTH (SYNC_DEPTH)
    ) u_rx (
        .clk         (clk),
        .reset       (reset),
        .rxd_i       (rxd),
        .load_o      (load),
        .data_o      (datain),
        .frame_err_o (rx_frame_err)
    );

    // TX FSM and handshake. txd and ready are registered here.
    // ready is re-armed one cycle after entry to T_IDLE, so an enout that is
    // still high at that point is not captured twice.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_q <= T_IDLE;
            tx_cnt_q   <= CNT_0;
            tx_bit_q   <= 3'd0;
            tx_shift_q <= 8'h00;
            txd_q      <= 1'b1;
            ready_q    <= 1'b0;
        end else begin
            case (tx_state_q)
                T_IDLE: begin
                    if (!ready_q) begin
                        ready_q <= 1'b1;
                    end else if (enout) begin
                        tx_shift_q <= dataout;
                        ready_q    <= 1'b0;
                        txd_q      <= 1'b0;
                        tx_cnt_q   <= FULL_M1;
                        tx_state_q <= T_START;
                    end
                end
                T_START: begin
                    if (tx_cnt_q == CNT_0) begin
                        txd_q      <= tx_shift_q[0];
                        tx_bit_q   <= 3'd0;
                        tx_cnt_q   <= FULL_M1;
                        tx_state_q <= T_DATA;
                    end else begin
                        tx_cnt_q <= tx_cnt_q - CW'(1);
                    end
                end
                T_DATA: begin
                    if (tx_cnt_q == CNT_0) begin
                        tx_cnt_q <= FULL_M1;
                        if (tx_bit_q == 3'd7) begin
                            txd_q      <= 1'b1;
                            tx_state_q <= T_STOP;
                        end else begin
                            // bit 0 of the shift register is always the bit on the wire
                            txd_q      <= tx_shift_q[1];
                            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                            tx_bit_q   <= tx_bit_q + 3'd1;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q - CW'(1);
                    end
                end
                T_STOP: begin
                    if (tx_cnt_q == CNT_0) begin
                        tx_state_q <= T_RELEASE;
                    end else begin
                        tx_cnt_q <= tx_cnt_q - CW'(1);
                    end
                end
                T_RELEASE: begin
                    if (!enout) begin
                        tx_state_q <= T_IDLE;
                    end
                end
                default: begin
                    tx_state_q <= T_IDLE;
                    txd_q      <= 1'b1;
                    ready_q    <= 1'b0;
                end
            endcase
        end
    end

    assign txd   = txd_q;
    assign ready = ready_q;

endmodule

// File: tb/tb_uart_byte_link.sv
// -----------------------------------------------------------------------------
// tb_uart_byte_link
// Self-checking bench for uart_byte_link at DIVISOR=16. A host UART model
// drives rxd. An ioports model offers bytes on enout/dataout. Monitors decode
// txd and watch load/datain, and they compare against queues of expected bytes.
// -----------------------------------------------------------------------------
module tb_uart_byte_link;

    localparam int DIV = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rxd = 1'b1;
    logic       enout = 1'b0;
    logic [7:0] dataout = 8'h00;
    logic       txd;
    logic       load;
    logic [7:0] datain;
    logic       ready;
    logic       rx_frame_err;

    int n_vec = 0;
    int n_bad = 0;

    logic [7:0] rx_exp[$];
    logic [7:0] rx_log[$];
    logic [7:0] tx_exp[$];
    int  err_exp = 0;
    int  err_seen = 0;
    int  load_seen = 0;
    int  tx_frames = 0;
    bit  tx_busy = 1'b0;
    logic load_prev = 1'b0;

    logic [7:0] tm_e;
    logic [7:0] tm_got;
    int         tm_bad;
    bit         tm_abort;
    logic       tm_lvl;

    uart_byte_link #(.DIVISOR(DIV), .SYNC_DEPTH(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .rxd          (rxd),
        .txd          (txd),
        .load         (load),
        .datain       (datain),
        .ready        (ready),
        .enout        (enout),
        .dataout      (dataout),
        .rx_frame_err (rx_frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // RX monitor: each load consumes the oldest expected byte.
    initial begin
        forever begin
            @(negedge clk);
            if (load === 1'b1) begin
                load_seen++;
                rx_log.push_back(datain);
                if (rx_exp.size() == 0) chk("rx_spurious_load", 32'd1, 32'd0);
                else chk("rx_byte", 32'(datain), 32'(rx_exp.pop_front()));
                if (load_prev) chk("load_width", 32'd2, 32'd1);
            end
            if (rx_frame_err === 1'b1) err_seen++;
            load_prev = load;
        end
    end

    // TX monitor: it compares a whole 10-bit frame, cycle by cycle, with the ideal waveform.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && txd === 1'b0) begin
                tx_busy = 1'b1;
                if (tx_exp.size() == 0) begin
                    chk("tx_spurious_frame", 32'd1, 32'd0);
                    tm_e = 8'h00;
                end else begin
                    tm_e = tx_exp[0];
                end
                tm_bad = 0;
                tm_got = 8'h00;
                tm_abort = 1'b0;
                for (int k = 0; k < 10 * DIV; k++) begin
                    if (k > 0) @(negedge clk);
                    if (reset) begin
                        tm_abort = 1'b1;
                        break;
                    end
                    if (k < DIV) tm_lvl = 1'b0;
                    else if (k >= 9 * DIV) tm_lvl = 1'b1;
                    else tm_lvl = tm_e[k / DIV - 1];
                    if (txd !== tm_lvl) tm_bad++;
                    if (k >= DIV && k < 9 * DIV && (k % DIV) == DIV / 2) tm_got[k / DIV - 1] = txd;
                end
                if (tx_exp.size() > 0) void'(tx_exp.pop_front());
                if (!tm_abort) begin
                    tx_frames++;
                    chk("tx_byte", 32'(tm_got), 32'(tm_e));
                    chk("tx_shape", tm_bad, 0);
                end
                tx_busy = 1'b0;
            end
        end
    end

    // Host UART sends one 8N1 frame. A stop bit of 0 gives a framing error.
    task automatic host_send(input logic [7:0] b, input logic stop_bit, input bit exp_load);
        if (exp_load) rx_exp.push_back(b);
        if (!stop_bit) err_exp++;
        @(negedge clk);
        rxd = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (DIV) @(negedge clk);
        end
        rxd = stop_bit;
        repeat (DIV) @(negedge clk);
        rxd = 1'b1;
    endtask

    // ioports model: it offers b and expects the wire to carry e. dataout is scrambled after capture.
    task automatic send_tx(input logic [7:0] b, input logic [7:0] e);
        int t;
        int hi;
        t = 0;
        while (ready !== 1'b1 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (ready !== 1'b1) begin
            chk("tx_ready_timeout", 32'd0, 32'd1);
            return;
        end
        tx_exp.push_back(e);
        dataout = b;
        enout = 1'b1;
        hi = 0;
        t = 0;
        while (ready === 1'b1 && t < 50) begin
            hi++;
            @(negedge clk);
            t++;
        end
        chk("tx_ready_drop", hi, 1);
        dataout = 8'($urandom);
        repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            chk("ready_low_enout", 32'(ready), 32'd0);
        end
        enout = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        repeat (4) @(negedge clk);
        while ((rx_exp.size() != 0 || tx_exp.size() != 0 || tx_busy) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("drain", rx_exp.size() + tx_exp.size(), 0);
    endtask

    // Reset is asserted in the middle of TX data bit 3; the host frame is then in RX bit 4.
    task automatic reset_mid_frame();
        int t;
        t = 0;
        while (txd !== 1'b0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("rst_txd_fall", 32'(txd), 32'd0);
        repeat (4 * DIV + 8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_txd_high", 32'(txd), 32'd1);
        chk("rst_ready_low", 32'(ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready_rise", 32'(ready), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int l0;
        int e0;
        int base;
        int t;
        logic [7:0] loop_bytes [2];
        logic [7:0] tx_set [4];
        loop_bytes = '{8'h30, 8'h0F};
        tx_set = '{8'hA5, 8'h12, 8'h34, 8'h56};

        // reset state
        repeat (4) @(negedge clk);
        chk("rst_txd", 32'(txd), 32'd1);
        chk("rst_load", 32'(load), 32'd0);
        chk("rst_datain", 32'(datain), 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_ferr", 32'(rx_frame_err), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 32'(ready), 32'd1);

        // plain RX byte; datain holds afterwards
        l0 = load_seen;
        host_send(8'h21, 1'b1, 1'b1);
        chk("rx21_loads", load_seen - l0, 1);
        chk("rx21_datain", 32'(datain), 32'h21);
        repeat (50) @(negedge clk);
        chk("rx21_hold", 32'(datain), 32'h21);
        chk("rx21_ferr", err_seen, 0);

        // framing error, then a long break, then a good byte
        l0 = load_seen;
        e0 = err_seen;
        host_send(8'h5A, 1'b0, 1'b0);
        chk("ferr_strobe", err_seen - e0, 1);
        chk("ferr_noload", load_seen - l0, 0);
        chk("ferr_hold", 32'(datain), 32'h21);
        rxd = 1'b0;
        repeat (40 * DIV) @(negedge clk);
        rxd = 1'b1;
        repeat (2 * DIV) @(negedge clk);
        chk("break_noload", load_seen - l0, 0);
        host_send(8'h3C, 1'b1, 1'b1);
        chk("after_break_load", load_seen - l0, 1);
        chk("after_break_data", 32'(datain), 32'h3C);
        chk("after_break_ferr", err_seen - e0, 1);

        // short glitch on rxd is ignored and RX stays ready
        l0 = load_seen;
        e0 = err_seen;
        @(negedge clk);
        rxd = 1'b0;
        repeat (5) @(negedge clk);
        rxd = 1'b1;
        repeat (3 * DIV) @(negedge clk);
        chk("glitch_noload", load_seen - l0, 0);
        chk("glitch_noferr", err_seen - e0, 0);
        host_send(8'hC9, 1'b1, 1'b1);
        chk("glitch_recover", load_seen - l0, 1);

        // TX sequence of four bytes
        foreach (tx_set[i]) send_tx(tx_set[i], tx_set[i]);
        drain();

        // random, simultaneous RX and TX traffic
        fork
            repeat (6) host_send(8'($urandom), 1'b1, 1'b1);
            repeat (6) begin
                logic [7:0] r;
                r = 8'($urandom);
                send_tx(r, r);
            end
        join
        drain();

        // loopback: received bytes are echoed onto TX
        base = rx_log.size();
        fork
            begin
                host_send(loop_bytes[0], 1'b1, 1'b1);
                host_send(loop_bytes[1], 1'b1, 1'b1);
            end
            for (int k = 0; k < 2; k++) begin
                t = 0;
                while (rx_log.size() <= base + k && t < 3000) begin
                    @(negedge clk);
                    t++;
                end
                if (rx_log.size() <= base + k) chk("echo_timeout", 32'd0, 32'd1);
                else send_tx(rx_log[base + k], loop_bytes[k]);
            end
        join
        drain();

        // reset mid-frame aborts both directions
        l0 = load_seen;
        t = tx_frames;
        fork
            host_send(8'hF5, 1'b1, 1'b0);
            begin
                repeat (16) @(negedge clk);
                send_tx(8'hC3, 8'hC3);
            end
            reset_mid_frame();
        join
        repeat (2 * DIV) @(negedge clk);
        chk("rst_no_load", load_seen - l0, 0);
        chk("rst_no_frame", tx_frames - t, 0);

        fork
            host_send(8'h7E, 1'b1, 1'b1);
            send_tx(8'h7E, 8'h7E);
        join
        drain();
        chk("post_rst_datain", 32'(datain), 32'h7E);

        chk("err_total", err_seen, err_exp);
        chk("load_total", load_seen, 12);
        chk("tx_frames_total", tx_frames, 13);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
